if_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Issues word fetches to instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs in a small FIFO.
- Presents the buffered instructions to the decode stage with valid/ready.
- On a taken-branch redirect from the MEM stage, flushes the FIFO and discards in-flight responses.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_prefetch_queue_fetch_fifo.sv | 64 ++++++
 rtl/if_prefetch_queue.sv | 115 +++++++++++
 tb/tb_if_prefetch_queue.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Clear the byte-offset bits of an address so it names a whole word.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; registered storage and a
// combinational head output. Flush wins over push and pop.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [AW:0]  count,
   output logic         empty,
   output logic         full
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (!(push && full && !do_pop));
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues word fetches over req/gnt/rvalid,
// buffers returned instructions with their PCs and hands them to decode.
// A taken-branch redirect flushes the buffer and discards in-flight words.
module if_prefetch_queue
   import if_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_n,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(MAX_OUT + 1);
   localparam logic [OW-1:0] MAX_OUT_CNT = OW'(MAX_OUT);
   localparam logic [AW+1:0] DEPTH_CRED  = (AW+2)'(DEPTH);

   logic            running;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   outstanding_nxt;
   logic [OW-1:0]   discard_cnt;
   logic [AW+1:0]   credit_used;
   logic [XLEN-1:0] redirect_tgt;
   logic            xfer;

   fetch_entry_t    fifo_head;
   fetch_entry_t    fifo_wdata;
   logic [AW:0]     fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_push;
   logic            fifo_pop;

   assign redirect_tgt = align_word(redirect_pc_i);
   assign credit_used  = {1'b0, fifo_count} + (AW+2)'(outstanding);

   assign imem_req_o  = running && (credit_used < DEPTH_CRED)
                        && (outstanding < MAX_OUT_CNT) && !redirect_i;
   assign imem_addr_o = fetch_pc;
   assign xfer        = imem_req_o && imem_gnt_i;

   assign fifo_push  = imem_rvalid_i && (discard_cnt == '0) && !redirect_i;
   assign fifo_pop   = id_valid_o && id_ready_i && !redirect_i;
   assign fifo_wdata = '{pc: resp_pc, instr: imem_rdata_i};

   assign id_valid_o = !fifo_empty;
   assign id_instr_o = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign id_pc_o    = fifo_empty ? '0 : fifo_head.pc;

   // Net in-flight count after this cycle's grant and response.
   always_comb begin
      outstanding_nxt = outstanding + OW'(xfer) - OW'(imem_rvalid_i);
   end

   // Requesting is held off by a registered flag (not rst_n directly) so
   // imem_req_o drops as soon as reset asserts and resumes glitch-free.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) running <= 1'b0;
      else        running <= 1'b1;
   end

   // Fetch/response PCs, outstanding credit and stale-response discard count.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         assert (!(imem_rvalid_i && outstanding == '0));
         assert (!(fifo_push && fifo_full && !fifo_pop));
         outstanding <= outstanding_nxt;
         if (redirect_i) begin
            fetch_pc    <= redirect_tgt;
            resp_pc     <= redirect_tgt;
            discard_cnt <= outstanding_nxt;
         end else begin
            if (xfer) fetch_pc <= fetch_pc + 32'd4;
            if (fifo_push) resp_pc <= resp_pc + 32'd4;
            if (imem_rvalid_i && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .flush     (redirect_i),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: an in-order memory model with
// configurable latency, a scoreboard of expected {pc, instr} per grant, and
// scenario tasks for streaming, backpressure, redirects and reset.
module tb_if_prefetch_queue;
   import if_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   if_prefetch_queue #(
      .DEPTH    (4),
      .MAX_OUT  (2),
      .RESET_PC (RST_PC)
   ) dut (
      .clk_i         (clk_i),
      .rst_n         (rst_n),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_instr_o    (id_instr_o),
      .id_pc_o       (id_pc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           mem_lat  = 1;
   bit           gnt_rand = 1'b0;
   int           deliv    = 0;
   logic [31:0]  exp_fetch_pc = RST_PC;
   pend_t        pend [$];
   fetch_entry_t exp_q [$];
   logic [31:0]  dpcs [$];
   logic [31:0]  dins [$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1357};
   endfunction

   // Memory model: in-order responses mem_lat cycles after the request cycle.
   initial begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(posedge clk_i);
         cyc++;
         #1;
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
         if (!rst_n) begin
            pend.delete();
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memf(pend[0].addr);
            void'(pend.pop_front());
         end
         imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         #2;
         if (rst_n && imem_req_o && imem_gnt_i) begin
            checks++;
            if (imem_addr_o !== exp_fetch_pc) begin
               failures++;
               $display("FAIL fetch_addr got=%h expected=%h", imem_addr_o, exp_fetch_pc);
            end
            pend.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
            exp_q.push_back('{pc: exp_fetch_pc, instr: memf(exp_fetch_pc)});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
         end
      end
   end

   // Decode-side monitor: compares every accepted head against the scoreboard.
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk_i);
         if (rst_n) begin
            if (!id_valid_o) begin
               checks++;
               if (id_instr_o !== NOP_INSTR || id_pc_o !== 32'h0) begin
                  failures++;
                  $display("FAIL empty_head instr=%h pc=%h expected instr=%h pc=0",
                           id_instr_o, id_pc_o, NOP_INSTR);
               end
            end else if (id_ready_i && !redirect_i) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_pop pc=%h expected no entry", id_pc_o);
               end else begin
                  e = exp_q.pop_front();
                  if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                     failures++;
                     $display("FAIL pop_order pc=%h instr=%h expected pc=%h instr=%h",
                              id_pc_o, id_instr_o, e.pc, e.instr);
                  end
               end
               dpcs.push_back(id_pc_o);
               dins.push_back(id_instr_o);
               deliv++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle=%0d expected finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic wait_deliv(input int d0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (deliv > d0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL deliver_timeout delivered=%0d expected>%0d", deliv, d0);
      end
   endtask

   // Caller is at posedge+1; redirect is held for exactly one cycle.
   task automatic do_redirect(input logic [31:0] t);
      redirect_i    = 1'b1;
      redirect_pc_i = t;
      exp_q.delete();
      exp_fetch_pc  = {t[31:2], 2'b00};
      step(1);
      redirect_i    = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl req=%b valid=%b expected 0 0", imem_req_o, id_valid_o);
      end
      checks++;
      if (id_instr_o !== NOP_INSTR || id_pc_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_head instr=%h pc=%h expected %h 0", id_instr_o, id_pc_o, NOP_INSTR);
      end
      exp_fetch_pc = RST_PC;
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      int r = -1;
      int v = -1;
      int cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (imem_req_o && r < 0) r = i;
         if (id_valid_o && v < 0) v = i;
         if (v >= 0) break;
      end
      checks++;
      if (v < 0 || r < 0 || v - r != 2) begin
         failures++;
         $display("FAIL fetch_latency got=%0d expected=2", v - r);
      end
      repeat (20) begin
         @(negedge clk_i);
         if (id_valid_o && id_ready_i) cnt++;
      end
      checks++;
      if (cnt != 20) begin
         failures++;
         $display("FAIL throughput got=%0d expected=20", cnt);
      end
   endtask

   task automatic test_backpressure();
      int d0;
      step(1);
      id_ready_i = 1'b0;
      repeat (10) begin
         @(negedge clk_i);
         checks++;
         if (exp_q.size() > 4) begin
            failures++;
            $display("FAIL credit_bound in_flight=%0d expected<=4", exp_q.size());
         end
      end
      checks++;
      if (exp_q.size() != 4 || imem_req_o !== 1'b0 || id_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL full_hold entries=%0d req=%b valid=%b expected 4 0 1",
                  exp_q.size(), imem_req_o, id_valid_o);
      end
      step(1);
      d0 = deliv;
      id_ready_i = 1'b1;
      repeat (6) @(negedge clk_i);
      checks++;
      if (deliv - d0 < 4) begin
         failures++;
         $display("FAIL drain got=%0d expected>=4", deliv - d0);
      end
   endtask

   task automatic test_redirect_latency();
      int d0;
      bit ok;
      mem_lat = 3;
      step(10);
      d0 = deliv;
      do_redirect(32'h0000_0100);
      wait_deliv(d0, ok);
      if (ok) begin
         checks++;
         if (dpcs[d0] !== 32'h100 || dins[d0] !== memf(32'h100)) begin
            failures++;
            $display("FAIL redirect_first pc=%h instr=%h expected pc=100 instr=%h",
                     dpcs[d0], dins[d0], memf(32'h100));
         end
      end
   endtask

   task automatic test_redirect_grant_rvalid();
      int d0;
      bit ok;
      mem_lat = 1;
      step(8);
      d0 = deliv;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0180;
      exp_q.delete();
      exp_fetch_pc  = 32'h0000_0180;
      #1;
      checks++;
      if (imem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL redirect_req got=%b expected=0", imem_req_o);
      end
      step(1);
      redirect_i = 1'b0;
      wait_deliv(d0, ok);
      if (ok) begin
         checks++;
         if (dpcs[d0] !== 32'h180) begin
            failures++;
            $display("FAIL redirect_rvalid_first pc=%h expected=00000180", dpcs[d0]);
         end
      end
   endtask

   task automatic test_misaligned_wrap();
      int d0;
      bit ok;
      step(4);
      d0 = deliv;
      do_redirect(32'h0000_0203);
      #1;
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
         failures++;
         $display("FAIL misaligned_addr req=%b addr=%h expected 1 00000200", imem_req_o, imem_addr_o);
      end
      wait_deliv(d0, ok);
      if (ok) begin
         checks++;
         if (dpcs[d0] !== 32'h200) begin
            failures++;
            $display("FAIL misaligned_pc pc=%h expected=00000200", dpcs[d0]);
         end
      end
      step(3);
      do_redirect(32'hFFFF_FFFC);
      #1;
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_first req=%b addr=%h expected 1 fffffffc", imem_req_o, imem_addr_o);
      end
      @(posedge clk_i);
      #2;
      checks++;
      if (imem_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL wrap_next addr=%h expected=00000000", imem_addr_o);
      end
      step(6);
   endtask

   task automatic test_back_to_back();
      int d0;
      bit ok;
      mem_lat = 3;
      step(8);
      d0 = deliv;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0300;
      exp_q.delete();
      exp_fetch_pc  = 32'h0000_0300;
      step(1);
      do_redirect(32'h0000_0400);
      wait_deliv(d0, ok);
      if (ok) begin
         checks++;
         if (dpcs[d0] !== 32'h400) begin
            failures++;
            $display("FAIL back_to_back pc=%h expected=00000400", dpcs[d0]);
         end
      end
   endtask

   task automatic test_random_gnt();
      int d0;
      bit ok;
      mem_lat  = 2;
      gnt_rand = 1'b1;
      repeat (60) begin
         step(1);
         id_ready_i = 1'($urandom_range(0, 1));
      end
      gnt_rand   = 1'b0;
      id_ready_i = 1'b1;
      d0 = deliv;
      wait_deliv(d0, ok);
   endtask

   task automatic test_async_reset();
      int d0;
      bit ok;
      mem_lat = 1;
      step(4);
      id_ready_i = 1'b0;
      step(2);
      @(posedge clk_i);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      exp_fetch_pc = RST_PC;
      #1;
      checks++;
      if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL async_reset req=%b valid=%b expected 0 0", imem_req_o, id_valid_o);
      end
      checks++;
      if (id_pc_o !== 32'h0 || id_instr_o !== NOP_INSTR) begin
         failures++;
         $display("FAIL async_reset_head pc=%h instr=%h expected 0 %h", id_pc_o, id_instr_o, NOP_INSTR);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n      = 1'b1;
      id_ready_i = 1'b1;
      d0 = deliv;
      wait_deliv(d0, ok);
      if (ok) begin
         checks++;
         if (dpcs[d0] !== RST_PC) begin
            failures++;
            $display("FAIL restart_pc pc=%h expected=%h", dpcs[d0], RST_PC);
         end
      end
      step(4);
   endtask

   initial begin
      rst_n         = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      id_ready_i    = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_grant_rvalid();
      test_misaligned_wrap();
      test_back_to_back();
      test_random_gnt();
      test_async_reset();
      repeat (3) @(posedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
